interp_ctrl: RTL and testbench
==============================

# interp_ctrl

Sequencer for the 8-wide HEVC sub-pixel FIR array. On a start pulse it walks the (NUM_PIXEL+7)-row reference block through the horizontal pass and then drives the vertical pass over the fed-back half-pel rows. It issues the row index and source select to the input mux, and the load strobes to the half-pel shift registers and the output fillers. It sits beside the interpolation datapath and replaces its free-running counter with a start/busy/done handshake.

## Interface
- NUM_PIXEL, 8, output pixels per row and per column.
- FIR_LAT, 2, cycles from row issue to valid FIR output (1..4).
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request one block; sampled only in IDLE.
- busy  out  1  high from the first HPASS cycle through the DONE cycle.
- done  out  1  one-cycle pulse in the DONE state.
- cnt  out  8  row index to the input mux.
- src_sel  out  1  0 = reference buffer, 1 = half-pel feedback.
- row_load  out  1  load strobe to the half-pel shift registers.
- out_load  out  1  write strobe to the output fillers.
- out_row  out  8  destination row for the current out_load.

## Operation
- Derived constants: H = NUM_PIXEL+7 horizontal rows; V = NUM_PIXEL vertical rows; H ≤ 255.
- States:
  - IDLE: wait for start.
  - HPASS: H cycles; cnt = 0..H-1; src_sel = 0.
  - HDRAIN: FIR_LAT cycles; cnt holds H-1.
  - VPASS: V cycles; cnt = 0..V-1; src_sel = 1.
  - VDRAIN: FIR_LAT cycles.
  - DONE: 1 cycle.
- Transitions:
  - IDLE → HPASS when start = 1.
  - HPASS → HDRAIN after row H-1 is issued.
  - HDRAIN → VPASS after FIR_LAT cycles.
  - VPASS → VDRAIN after row V-1 is issued.
  - VDRAIN → DONE after FIR_LAT cycles.
  - DONE → IDLE unconditionally.
- Issue tracking: each HPASS or VPASS cycle pushes {valid=1, pass, row=cnt} into a FIR_LAT-deep tag pipeline. All other states push valid=0.
- Pipeline output:
  - row_load = valid && pass==H.
  - out_load = valid && pass==V.
  - out_row = tag row when out_load = 1, otherwise 0.
- row_load and out_load are never high in the same cycle; the drain states guarantee this.
- start is ignored in every state except IDLE, including DONE. Holding start high restarts one cycle after DONE.
- src_sel stays 1 through VDRAIN and DONE, and returns to 0 in IDLE.
- cnt returns to 0 in IDLE.
- Reset mid-operation: state goes to IDLE and the tag pipeline is cleared. No strobe may appear after the reset cycle.
- Reset value of every output: busy 0, done 0, cnt 0, src_sel 0, row_load 0, out_load 0, out_row 0.

## Timing
- All outputs are registered.
- Cycle 0 is the first cycle after the edge that samples start=1 in IDLE.
- Defaults (NUM_PIXEL=8, FIR_LAT=2, H=15, V=8):

| Event | Cycles |
|---|---|
| HPASS | 0..14 |
| row_load high | 2..16 |
| HDRAIN | 15..16 |
| VPASS | 17..24 (src_sel=1 from cycle 17) |
| out_load high | 19..26, out_row 0..7 |
| VDRAIN | 25..26 |
| DONE, done=1 | 27 |
| busy high | 0..27 |

- General form:
  - row_load high for cycles FIR_LAT .. H+FIR_LAT-1.
  - done at cycle H+V+2·FIR_LAT.
  - Minimum start-to-start period is H+V+2·FIR_LAT+2 cycles.
- Latency from a row issue to its strobe is exactly FIR_LAT cycles.

## Test plan
- Reset, then start pulse at cycle 0 (defaults):
  - cnt sequence 0..14, then holds 14 for 2 cycles, then 0..7.
  - row_load count = 15; out_load count = 8 with out_row 0..7.
  - done only at cycle 27.
- start held high for 60 cycles:
  - two complete blocks.
  - second HPASS begins 29 cycles after the first.
  - done pulses at cycles 27 and 56.
- start pulsed at cycle 10 while busy → ignored; exactly one done, at cycle 27.
- rst asserted at cycle 20, during VPASS:
  - next cycle all outputs at reset values.
  - no out_load for 10 cycles.
  - a new start produces a full, correct block.
- FIR_LAT=4, NUM_PIXEL=4:
  - row_load high cycles 4..14.
  - VPASS 15..18; out_load high cycles 19..22.
  - done at cycle 23.
- Assertion across all runs:
  - row_load && out_load never both high.
  - busy low ⇒ no strobes.

Source files
------------

// File: rtl/interp_ctrl.sv
// rtl/interp_ctrl.sv - start/busy/done sequencer for the 8-wide HEVC sub-pixel FIR array
module interp_ctrl #(
   parameter int NUM_PIXEL = 8,
   parameter int FIR_LAT   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic [7:0] cnt,
   output logic       src_sel,
   output logic       row_load,
   output logic       out_load,
   output logic [7:0] out_row
);

   // Last row index of each pass and last drain cycle, pre-sized for compares
   localparam logic [7:0] H_LAST   = 8'(NUM_PIXEL + 6);
   localparam logic [7:0] V_LAST   = 8'(NUM_PIXEL - 1);
   localparam logic [2:0] LAT_LAST = 3'(FIR_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HPASS  = 3'd1,
      S_HDRAIN = 3'd2,
      S_VPASS  = 3'd3,
      S_VDRAIN = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] lat_q, lat_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       src_q, src_d;

   // Tag = {h-row issued, v-row issued, v-row index}; the row field is kept
   // zero for horizontal issues so it can drive out_row directly.
   logic [9:0] tag_q [FIR_LAT];
   logic [9:0] tag_push;

   // Next-state, row counter and drain counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lat_d   = lat_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = 8'd0;
            lat_d = 3'd0;
            if (start) begin
               state_d = S_HPASS;
            end
         end
         S_HPASS: begin
            if (cnt_q == H_LAST) begin
               state_d = S_HDRAIN;
               lat_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_HDRAIN: begin
            if (lat_q == LAT_LAST) begin
               state_d = S_VPASS;
               cnt_d   = 8'd0;
            end else begin
               lat_d = lat_q + 3'd1;
            end
         end
         S_VPASS: begin
            if (cnt_q == V_LAST) begin
               state_d = S_VDRAIN;
               lat_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_VDRAIN: begin
            if (lat_q == LAT_LAST) begin
               state_d = S_DONE;
            end else begin
               lat_d = lat_q + 3'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
            lat_d   = 3'd0;
         end
      endcase
   end

   // Status outputs are decoded from the next state so they register in step with it
   always_comb begin
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
      src_d  = (state_d == S_VPASS) || (state_d == S_VDRAIN) || (state_d == S_DONE);
   end

   // Tag for the row issued this cycle; drain and idle cycles push an empty tag
   always_comb begin
      tag_push = 10'd0;
      if (state_q == S_HPASS) begin
         tag_push[9] = 1'b1;
      end else if (state_q == S_VPASS) begin
         tag_push[8]   = 1'b1;
         tag_push[7:0] = cnt_q;
      end
   end

   // Control state and registered status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         lat_q   <= 3'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         src_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lat_q   <= lat_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         src_q   <= src_d;
      end
   end

   // FIR_LAT-deep tag pipeline; its last stage is the strobe output register
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIR_LAT; i++) begin
            tag_q[i] <= 10'd0;
         end
      end else begin
         tag_q[0] <= tag_push;
         for (int i = 1; i < FIR_LAT; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign cnt      = cnt_q;
   assign src_sel  = src_q;
   assign row_load = tag_q[FIR_LAT-1][9];
   assign out_load = tag_q[FIR_LAT-1][8];
   assign out_row  = tag_q[FIR_LAT-1][7:0];

endmodule

// File: tb/tb_interp_ctrl.sv
// tb/tb_interp_ctrl.sv - self-checking bench for interp_ctrl
module tb_interp_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       start2;
   logic       busy, done, src_sel, row_load, out_load;
   logic [7:0] cnt, out_row;
   logic       busy2, done2, src_sel2, row_load2, out_load2;
   logic [7:0] cnt2, out_row2;

   int n_checks = 0;
   int n_fail   = 0;
   int t        = 0;
   int t0       = 0;
   int dq[$];
   bit chk_en   = 1'b0;

   // behavioural model of the default instance: idle, or k cycles into a block
   bit m_active = 1'b0;
   int m_k      = 0;

   typedef struct {
      int          cyc;
      logic [20:0] exp;
   } vec_t;
   vec_t tbl[13];

   always #5 clk = ~clk;

   interp_ctrl #(.NUM_PIXEL(8), .FIR_LAT(2)) dut (
      .clk(clk), .rst(rst), .start(start),
      .busy(busy), .done(done), .cnt(cnt), .src_sel(src_sel),
      .row_load(row_load), .out_load(out_load), .out_row(out_row)
   );

   interp_ctrl #(.NUM_PIXEL(4), .FIR_LAT(4)) dut2 (
      .clk(clk), .rst(rst), .start(start2),
      .busy(busy2), .done(done2), .cnt(cnt2), .src_sel(src_sel2),
      .row_load(row_load2), .out_load(out_load2), .out_row(out_row2)
   );

   function automatic logic [20:0] pk(input bit b, input bit d, input int c, input bit s,
                                      input bit rl, input bit ol, input int orow);
      return {b, d, 8'(c), s, rl, ol, 8'(orow)};
   endfunction

   // expected outputs k cycles after the block began, from the pass lengths
   function automatic logic [20:0] exp_at(input int k, input int h, input int v, input int l);
      int  tot;
      int  c;
      bit  rl, ol;
      tot = h + v + 2 * l;
      if (k < 0 || k > tot) return '0;
      if (k < h)              c = k;
      else if (k < h + l)     c = h - 1;
      else if (k < h + l + v) c = k - h - l;
      else                    c = v - 1;
      rl = (k >= l) && (k < h + l);
      ol = (k >= h + 2 * l) && (k < h + 2 * l + v);
      return pk(1'b1, k == tot, c, k >= h + l, rl, ol, ol ? k - h - 2 * l : 0);
   endfunction

   function automatic logic [20:0] vec1();
      return {busy, done, cnt, src_sel, row_load, out_load, out_row};
   endfunction

   function automatic logic [20:0] vec2();
      return {busy2, done2, cnt2, src_sel2, row_load2, out_load2, out_row2};
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, t, act, expv);
      end
   endtask

   // check the current cycle against the model, then drive one clock edge
   task automatic cycle(input bit s, input bit r);
      cmp("model", 32'(vec1()), 32'(m_active ? exp_at(m_k, 15, 8, 2) : 21'd0));
      if (done) dq.push_back(t - t0);
      start = s;
      rst   = r;
      @(posedge clk);
      if (r) m_active = 1'b0;
      else if (!m_active) begin
         if (s) begin
            m_active = 1'b1;
            m_k      = 0;
         end
      end else if (m_k == 15 + 8 + 4) m_active = 1'b0;
      else m_k++;
      t++;
      @(negedge clk);
   endtask

   // structural properties on both instances every cycle
   always @(negedge clk) begin
      if (chk_en) begin
         n_checks++;
         if ((row_load && out_load) || (!busy && (row_load || out_load))) begin
            n_fail++;
            $display("FAIL strobe_prop at cycle %0d: busy=%b row_load=%b out_load=%b", t, busy, row_load, out_load);
         end
         n_checks++;
         if ((row_load2 && out_load2) || (!busy2 && (row_load2 || out_load2))) begin
            n_fail++;
            $display("FAIL strobe_prop2 at cycle %0d: busy=%b row_load=%b out_load=%b", t, busy2, row_load2, out_load2);
         end
      end
   end

   initial begin
      int ol_cnt, rl_cnt, d2_cyc, rlo, rhi;
      tbl[0]  = '{0,  pk(1, 0, 0,  0, 0, 0, 0)};
      tbl[1]  = '{1,  pk(1, 0, 1,  0, 0, 0, 0)};
      tbl[2]  = '{2,  pk(1, 0, 2,  0, 1, 0, 0)};
      tbl[3]  = '{14, pk(1, 0, 14, 0, 1, 0, 0)};
      tbl[4]  = '{15, pk(1, 0, 14, 0, 1, 0, 0)};
      tbl[5]  = '{16, pk(1, 0, 14, 0, 1, 0, 0)};
      tbl[6]  = '{17, pk(1, 0, 0,  1, 0, 0, 0)};
      tbl[7]  = '{19, pk(1, 0, 2,  1, 0, 1, 0)};
      tbl[8]  = '{24, pk(1, 0, 7,  1, 0, 1, 5)};
      tbl[9]  = '{25, pk(1, 0, 7,  1, 0, 1, 6)};
      tbl[10] = '{26, pk(1, 0, 7,  1, 0, 1, 7)};
      tbl[11] = '{27, pk(1, 1, 7,  1, 0, 0, 0)};
      tbl[12] = '{28, pk(0, 0, 0,  0, 0, 0, 0)};

      rst = 1'b1; start = 1'b0; start2 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      cmp("reset_vals", 32'(vec1()), 32'd0);
      cmp("reset_vals2", 32'(vec2()), 32'd0);
      cycle(0, 0);

      // single block against the timing table
      cycle(1, 0);
      t0 = t;
      dq.delete();
      foreach (tbl[i]) begin
         while (t - t0 < tbl[i].cyc) cycle(0, 0);
         cmp($sformatf("table_c%0d", tbl[i].cyc), 32'(vec1()), 32'(tbl[i].exp));
      end
      cycle(0, 0);
      cmp("table_done_cnt", dq.size(), 1);

      // start held high: back-to-back blocks
      dq.delete();
      cycle(1, 0);
      t0 = t;
      while (t - t0 < 59) cycle(1, 0);
      cmp("held_done_cnt", dq.size(), 2);
      cmp("held_done0", dq.size() > 0 ? dq[0] : -1, 27);
      cmp("held_done1", dq.size() > 1 ? dq[1] : -1, 56);
      cycle(0, 1);
      cycle(0, 0);

      // start while busy is ignored
      dq.delete();
      cycle(1, 0);
      t0 = t;
      while (t - t0 < 10) cycle(0, 0);
      cycle(1, 0);
      while (t - t0 < 40) cycle(0, 0);
      cmp("busy_start_cnt", dq.size(), 1);
      cmp("busy_start_done", dq.size() > 0 ? dq[0] : -1, 27);

      // reset during VPASS
      cycle(1, 0);
      t0 = t;
      while (t - t0 < 20) cycle(0, 0);
      cycle(0, 1);
      cmp("rst_mid_vals", 32'(vec1()), 32'd0);
      ol_cnt = 0;
      repeat (10) begin
         if (out_load) ol_cnt++;
         cycle(0, 0);
      end
      cmp("rst_mid_no_outload", ol_cnt, 0);
      dq.delete();
      cycle(1, 0);
      t0 = t;
      while (t - t0 < 30) cycle(0, 0);
      cmp("rst_restart_done", dq.size() == 1 ? dq[0] : -1, 27);

      // NUM_PIXEL=4, FIR_LAT=4 instance
      start2 = 1'b1;
      cycle(0, 0);
      start2 = 1'b0;
      rl_cnt = 0; d2_cyc = -1; rlo = -1; rhi = -1;
      for (int k = 0; k <= 26; k++) begin
         cmp($sformatf("p4l4_c%0d", k), 32'(vec2()), 32'(exp_at(k, 11, 4, 4)));
         if (row_load2) begin
            rl_cnt++;
            if (rlo < 0) rlo = k;
            rhi = k;
         end
         if (done2) d2_cyc = k;
         cycle(0, 0);
      end
      cmp("p4l4_rl_cnt", rl_cnt, 11);
      cmp("p4l4_rl_first", rlo, 4);
      cmp("p4l4_rl_last", rhi, 14);
      cmp("p4l4_done", d2_cyc, 23);

      // random start/reset against the model
      for (int i = 0; i < 1500; i++) begin
         cycle($urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
      end
      cycle(0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
